// File: rtl/comb_nonspec_alloc_mon_pkg.sv
// Shared constants and helpers for the combined VC/switch allocator with starvation monitor.
// The localparams describe the default router configuration; instances derive their own sizes.
package comb_nonspec_alloc_mon_pkg;

    localparam int unsigned DEF_V = 4;
    localparam int unsigned DEF_P = 5;
    localparam int unsigned PV    = DEF_P * DEF_V;
    localparam int unsigned PVV   = PV * DEF_V;
    localparam int unsigned P_1   = DEF_P - 1;
    localparam int unsigned PP_1  = DEF_P * P_1;

    // Destination bits skip the input's own port index.
    function automatic int unsigned dest_bit_to_port(input int unsigned in_port,
                                                     input int unsigned bit_idx);
        return (bit_idx < in_port) ? bit_idx : bit_idx + 1;
    endfunction

    function automatic int unsigned oh_to_idx(input logic [63:0] oh);
        int unsigned r;
        r = 0;
        for (int unsigned k = 64; k > 0; k--) begin
            if (oh[k-1]) r = k - 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comb_nonspec_alloc_mon_rr_arbiter.sv
// N-way round-robin arbiter: the search starts at an externally held pointer.
module rr_arbiter_ptr #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
        end
        gnt_valid = |req;
    end

endmodule

// File: rtl/comb_nonspec_alloc_mon.sv
// Single-cycle input-first separable VC/switch allocator with per-IVC starvation monitor.
// Grants are combinational; only the round-robin pointers and debug state are registered.
module comb_nonspec_alloc_mon
    import comb_nonspec_alloc_mon_pkg::*;
#(
    parameter int unsigned V           = DEF_V,
    parameter int unsigned P           = DEF_P,
    parameter int unsigned STARV_W     = 8,
    parameter int unsigned STARV_LIMIT = 200,
    parameter bit          DEBUG_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P*V-1:0]         ivc_request_all,
    input  logic [P*V*(P-1)-1:0]   dest_port_all,
    input  logic [P*V-1:0]         ovc_is_assigned_all,
    input  logic [P*V-1:0]         assigned_ovc_not_full_all,
    input  logic [P*V*V-1:0]       masked_ovc_request_all,
    input  logic                   trigger_clr,
    output logic [P*V-1:0]         ivc_num_getting_sw_grant,
    output logic [P*V-1:0]         ivc_num_getting_ovc_grant,
    output logic [P*V*V-1:0]       granted_ovc_num_all,
    output logic [P*(P-1)-1:0]     granted_dest_port_all,
    output logic [P-1:0]           any_ivc_sw_request_granted_all,
    output logic [P*V-1:0]         ovc_allocated_all,
    output logic                   trigger,
    output logic [31:0]            trace
);

    localparam int unsigned NPV = P * V;
    localparam int unsigned NP_1 = P - 1;
    localparam int unsigned VW  = (V > 1) ? $clog2(V) : 1;
    localparam int unsigned PW  = $clog2(P);

    logic [NPV-1:0]                eligible;
    logic [NPV-1:0][NP_1-1:0]      dest_lo;
    logic [P-1:0][V-1:0]           s1_gnt;
    logic [P-1:0]                  s1_valid;
    logic [P-1:0][NP_1-1:0]        s1_dest;
    logic [P-1:0]                  need_ovc;
    logic [P-1:0][V-1:0]           sel_mask;
    logic [P-1:0][P-1:0]           s2_req;
    logic [P-1:0][P-1:0]           s2_gnt;
    logic [P-1:0]                  s2_valid;
    logic [P-1:0]                  in_won;
    logic [P-1:0][V-1:0]           vc_req;
    logic [P-1:0][V-1:0]           vc_gnt;
    logic [P-1:0]                  vc_valid;
    logic [P-1:0][PW-1:0]          out_ptr;
    logic [P-1:0][VW-1:0]          vc_ptr;

    always_comb begin
        eligible = '0;
        dest_lo  = '0;
        for (int unsigned n = 0; n < NPV; n++) begin
            for (int unsigned j = 0; j < NP_1; j++) begin
                if (dest_port_all[n*NP_1+j] && (dest_lo[n] == '0)) dest_lo[n][j] = 1'b1;
            end
            eligible[n] = ivc_request_all[n] && (|dest_port_all[n*NP_1 +: NP_1]) &&
                          (ovc_is_assigned_all[n] ? assigned_ovc_not_full_all[n]
                                                  : |masked_ovc_request_all[n*V +: V]);
        end
    end

    // Stage 1: per-input arbitration; pointer moves only when the input also wins stage 2.
    for (genvar gi = 0; gi < P; gi++) begin : g_in
        if (V > 1) begin : g_arb
            logic [VW-1:0] in_ptr;

            rr_arbiter_ptr #(.N(V)) u_s1 (
                .req       (eligible[gi*V +: V]),
                .ptr       (in_ptr),
                .gnt       (s1_gnt[gi]),
                .gnt_valid (s1_valid[gi])
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ptr <= '0;
                end else if (in_won[gi]) begin
                    in_ptr <= VW'((oh_to_idx(64'(s1_gnt[gi])) + 1) % V);
                end
            end
        end else begin : g_pass
            assign s1_gnt[gi]   = eligible[gi*V +: V];
            assign s1_valid[gi] = eligible[gi];
        end
    end

    always_comb begin
        s1_dest  = '0;
        need_ovc = '0;
        sel_mask = '0;
        s2_req   = '0;
        for (int unsigned i = 0; i < P; i++) begin
            for (int unsigned v = 0; v < V; v++) begin
                if (s1_gnt[i][v]) begin
                    s1_dest[i] = s1_dest[i] | dest_lo[i*V+v];
                    if (!ovc_is_assigned_all[i*V+v]) begin
                        need_ovc[i] = 1'b1;
                        sel_mask[i] = masked_ovc_request_all[(i*V+v)*V +: V];
                    end
                end
            end
            for (int unsigned o = 0; o < P; o++) begin
                for (int unsigned j = 0; j < NP_1; j++) begin
                    if (s1_valid[i] && s1_dest[i][j] && (dest_bit_to_port(i, j) == o))
                        s2_req[o][i] = 1'b1;
                end
            end
        end
    end

    for (genvar go = 0; go < P; go++) begin : g_out
        rr_arbiter_ptr #(.N(P)) u_s2 (
            .req       (s2_req[go]),
            .ptr       (out_ptr[go]),
            .gnt       (s2_gnt[go]),
            .gnt_valid (s2_valid[go])
        );

        rr_arbiter_ptr #(.N(V)) u_vc (
            .req       (vc_req[go]),
            .ptr       (vc_ptr[go]),
            .gnt       (vc_gnt[go]),
            .gnt_valid (vc_valid[go])
        );
    end

    // Only one input wins each output, so each VC arbiter sees at most one request mask.
    always_comb begin
        in_won = '0;
        vc_req = '0;
        for (int unsigned o = 0; o < P; o++) begin
            for (int unsigned i = 0; i < P; i++) begin
                if (s2_gnt[o][i]) begin
                    in_won[i] = 1'b1;
                    if (need_ovc[i]) vc_req[o] = sel_mask[i];
                end
            end
        end
    end

    always_comb begin
        ivc_num_getting_sw_grant       = '0;
        ivc_num_getting_ovc_grant      = '0;
        granted_ovc_num_all            = '0;
        granted_dest_port_all          = '0;
        any_ivc_sw_request_granted_all = '0;
        ovc_allocated_all              = '0;
        if (!reset) begin
            for (int unsigned i = 0; i < P; i++) begin
                if (in_won[i]) begin
                    any_ivc_sw_request_granted_all[i]   = 1'b1;
                    granted_dest_port_all[i*NP_1 +: NP_1] = s1_dest[i];
                    for (int unsigned v = 0; v < V; v++) begin
                        if (s1_gnt[i][v]) ivc_num_getting_sw_grant[i*V+v] = 1'b1;
                    end
                end
                for (int unsigned o = 0; o < P; o++) begin
                    if (s2_gnt[o][i] && need_ovc[i]) begin
                        ovc_allocated_all[o*V +: V] = vc_gnt[o];
                        for (int unsigned v = 0; v < V; v++) begin
                            if (s1_gnt[i][v] && !ovc_is_assigned_all[i*V+v]) begin
                                ivc_num_getting_ovc_grant[i*V+v]      = 1'b1;
                                granted_ovc_num_all[(i*V+v)*V +: V]   = vc_gnt[o];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_ptr <= '0;
            vc_ptr  <= '0;
        end else begin
            for (int unsigned o = 0; o < P; o++) begin
                if (s2_valid[o]) out_ptr[o] <= PW'((oh_to_idx(64'(s2_gnt[o])) + 1) % P);
                if (vc_valid[o]) vc_ptr[o]  <= VW'((oh_to_idx(64'(vc_gnt[o])) + 1) % V);
            end
        end
    end

    if (DEBUG_EN) begin : g_dbg
        logic [NPV-1:0][STARV_W-1:0] starv_cnt;
        logic [15:0]                 cycle_cnt;
        logic [7:0]                  event_cnt;
        logic [23:0]                 trace_lo;
        logic                        trig_q;
        logic                        hit;
        logic [7:0]                  hit_idx;

        always_comb begin
            hit     = 1'b0;
            hit_idx = '0;
            for (int unsigned n = NPV; n > 0; n--) begin
                if (starv_cnt[n-1] == STARV_W'(STARV_LIMIT)) begin
                    hit     = 1'b1;
                    hit_idx = 8'(n - 1);
                end
            end
        end

        // A crossing beats a simultaneous clear and refreshes the frozen trace fields.
        always_ff @(posedge clk) begin
            if (reset) begin
                starv_cnt <= '0;
                cycle_cnt <= '0;
                event_cnt <= '0;
                trace_lo  <= '0;
                trig_q    <= 1'b0;
            end else begin
                cycle_cnt <= cycle_cnt + 16'd1;
                for (int unsigned n = 0; n < NPV; n++) begin
                    if (!ivc_request_all[n] || ivc_num_getting_sw_grant[n])
                        starv_cnt[n] <= '0;
                    else if (starv_cnt[n] != '1)
                        starv_cnt[n] <= starv_cnt[n] + 1'b1;
                end
                if (hit) begin
                    if (event_cnt != 8'hFF) event_cnt <= event_cnt + 8'd1;
                    if (!trig_q || trigger_clr) trace_lo <= {hit_idx, cycle_cnt};
                    trig_q <= 1'b1;
                end else if (trigger_clr) begin
                    trig_q <= 1'b0;
                end
            end
        end

        assign trigger = trig_q;
        assign trace   = {event_cnt, trace_lo};
    end else begin : g_nodbg
        logic unused_trigger_clr;
        assign unused_trigger_clr = trigger_clr;
        assign trigger = 1'b0;
        assign trace   = '0;
    end

endmodule

// File: tb/tb_comb_nonspec_alloc_mon.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle, a negedge monitor checks both builds.
module tb_comb_nonspec_alloc_mon;

    localparam int unsigned P = 5;
    localparam int unsigned V = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  ivc_request_all;
    logic [39:0] dest_port_all;
    logic [9:0]  ovc_is_assigned_all;
    logic [9:0]  assigned_ovc_not_full_all;
    logic [19:0] masked_ovc_request_all;
    logic        trigger_clr;

    logic [9:0]  sw1, ovcg1, alloc1, sw0, ovcg0, alloc0;
    logic [19:0] ovcn1, gdest1, ovcn0, gdest0;
    logic [4:0]  any1, any0;
    logic        trig1, trig0;
    logic [31:0] trace1, trace0;

    always #5 clk = ~clk;

    comb_nonspec_alloc_mon #(.V(V), .P(P), .STARV_W(8), .STARV_LIMIT(4), .DEBUG_EN(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .ivc_request_all(ivc_request_all), .dest_port_all(dest_port_all),
        .ovc_is_assigned_all(ovc_is_assigned_all), .assigned_ovc_not_full_all(assigned_ovc_not_full_all),
        .masked_ovc_request_all(masked_ovc_request_all), .trigger_clr(trigger_clr),
        .ivc_num_getting_sw_grant(sw1), .ivc_num_getting_ovc_grant(ovcg1), .granted_ovc_num_all(ovcn1),
        .granted_dest_port_all(gdest1), .any_ivc_sw_request_granted_all(any1), .ovc_allocated_all(alloc1),
        .trigger(trig1), .trace(trace1)
    );

    comb_nonspec_alloc_mon #(.V(V), .P(P), .STARV_W(8), .STARV_LIMIT(4), .DEBUG_EN(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .ivc_request_all(ivc_request_all), .dest_port_all(dest_port_all),
        .ovc_is_assigned_all(ovc_is_assigned_all), .assigned_ovc_not_full_all(assigned_ovc_not_full_all),
        .masked_ovc_request_all(masked_ovc_request_all), .trigger_clr(trigger_clr),
        .ivc_num_getting_sw_grant(sw0), .ivc_num_getting_ovc_grant(ovcg0), .granted_ovc_num_all(ovcn0),
        .granted_dest_port_all(gdest0), .any_ivc_sw_request_granted_all(any0), .ovc_allocated_all(alloc0),
        .trigger(trig0), .trace(trace0)
    );

    typedef struct {
        string       name;
        logic [9:0]  sw;
        logic [9:0]  ovcg;
        logic [19:0] ovcn;
        logic [19:0] gdest;
        logic [4:0]  any;
        logic [9:0]  alloc;
        logic        trig;
        logic [31:0] trace;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cmp_grants(input string nm, input exp_t e, input logic [9:0] sw, input logic [9:0] ovcg,
                              input logic [19:0] ovcn, input logic [19:0] gdest, input logic [4:0] any,
                              input logic [9:0] alloc);
        chk({nm, " sw_grant"},  32'(sw),    32'(e.sw));
        chk({nm, " ovc_grant"}, 32'(ovcg),  32'(e.ovcg));
        chk({nm, " ovc_num"},   32'(ovcn),  32'(e.ovcn));
        chk({nm, " dest"},      32'(gdest), 32'(e.gdest));
        chk({nm, " any"},       32'(any),   32'(e.any));
        chk({nm, " alloc"},     32'(alloc), 32'(e.alloc));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp_grants({e.name, "/dbg1"}, e, sw1, ovcg1, ovcn1, gdest1, any1, alloc1);
            cmp_grants({e.name, "/dbg0"}, e, sw0, ovcg0, ovcn0, gdest0, any0, alloc0);
            chk({e.name, "/dbg1 trigger"}, 32'(trig1), 32'(e.trig));
            chk({e.name, "/dbg1 trace"},   trace1,     e.trace);
            chk({e.name, "/dbg0 trigger"}, 32'(trig0), 32'd0);
            chk({e.name, "/dbg0 trace"},   trace0,     32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ivc_request_all           = '0;
        dest_port_all             = '0;
        ovc_is_assigned_all       = '0;
        assigned_ovc_not_full_all = '0;
        masked_ovc_request_all    = '0;
        trigger_clr               = 1'b0;
    endtask

    task automatic set_ivc(input int unsigned ivc, input logic [3:0] dest, input logic asg,
                           input logic nf, input logic [1:0] msk);
        ivc_request_all[ivc]           = 1'b1;
        dest_port_all[ivc*4 +: 4]      = dest;
        ovc_is_assigned_all[ivc]       = asg;
        assigned_ovc_not_full_all[ivc] = nf;
        masked_ovc_request_all[ivc*2 +: 2] = msk;
    endtask

    task automatic push(input string nm, input logic [9:0] sw, input logic [9:0] ovcg, input logic [19:0] ovcn,
                        input logic [19:0] gdest, input logic [4:0] any, input logic [9:0] alloc,
                        input logic trig, input logic [31:0] tr);
        exp_t e;
        e.name = nm; e.sw = sw; e.ovcg = ovcg; e.ovcn = ovcn; e.gdest = gdest;
        e.any = any; e.alloc = alloc; e.trig = trig; e.trace = tr;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input string nm, input logic trig, input logic [31:0] tr);
        push(nm, '0, '0, '0, '0, '0, '0, trig, tr);
    endtask

    task automatic reset_pulse(input string nm);
        step();
        reset = 1'b1;
        push_idle(nm, 1'b0, 32'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin : driver
        clear_in();
        reset = 1'b1;
        for (int unsigned n = 0; n < 10; n++) set_ivc(n, 4'b0001, 1'b1, 1'b1, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step();
            push_idle("rst_hold", 1'b0, 32'd0);
        end
        step();
        reset = 1'b0;
        push("first_grant", 10'h005, '0, '0, 20'h00011, 5'b00011, '0, 1'b0, 32'd0);

        reset_pulse("rst_mid");
        clear_in();
        set_ivc(0, 4'b0001, 1'b1, 1'b1, 2'b00);
        set_ivc(4, 4'b0010, 1'b1, 1'b1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            if (k % 2 == 0) push("alt_p0", 10'h001, '0, '0, 20'h00001, 5'b00001, '0, 1'b0, 32'd0);
            else            push("alt_p2", 10'h010, '0, '0, 20'h00200, 5'b00100, '0, 1'b0, 32'd0);
        end

        reset_pulse("rst_c");
        clear_in();
        set_ivc(7, 4'b1000, 1'b0, 1'b0, 2'b11);
        push("ovc_first", 10'h080, 10'h080, 20'h04000, 20'h08000, 5'b01000, 10'h100, 1'b0, 32'd0);
        step();
        push("ovc_second", 10'h080, 10'h080, 20'h08000, 20'h08000, 5'b01000, 10'h200, 1'b0, 32'd0);

        reset_pulse("rst_d");
        clear_in();
        set_ivc(3, 4'b0001, 1'b1, 1'b0, 2'b00);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            if (c < 6) push_idle("starve_wait", 1'b0, 32'd0);
            else       push_idle("starve_fire", 1'b1, 32'h0103_0004);
        end
        step();
        set_ivc(4, 4'b0001, 1'b1, 1'b0, 2'b00);
        push_idle("trace_frozen", 1'b1, 32'h0103_0004);
        for (int c = 8; c <= 10; c++) begin
            step();
            push_idle("trace_frozen", 1'b1, 32'h0103_0004);
        end
        step();
        trigger_clr = 1'b1;
        push_idle("clr_vs_cross", 1'b1, 32'h0103_0004);
        step();
        push_idle("cross_wins", 1'b1, 32'h0204_000A);
        step();
        trigger_clr = 1'b0;
        push_idle("clr_applied", 1'b0, 32'h0204_000A);
        step();
        push_idle("trace_held", 1'b0, 32'h0204_000A);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
